// File: rtl/eth_tx_scheduler.sv
// eth_tx_scheduler: round-robin frame arbiter adding preamble/SFD, zero padding and IFG, one byte per BYTE_CYCLES clocks
module eth_tx_scheduler #(
    parameter int NUM_SRC        = 2,
    parameter int BYTE_CYCLES    = 4,
    parameter int PREAMBLE_BYTES = 7,
    parameter int IFG_BYTES      = 12,
    parameter int MIN_PAYLOAD    = 60
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_SRC-1:0]   src_valid,
    input  logic [8*NUM_SRC-1:0] src_data,
    input  logic [NUM_SRC-1:0]   src_last,
    output logic [NUM_SRC-1:0]   src_ready,
    output logic                 valid_out,
    output logic [7:0]           byte_out,
    output logic [NUM_SRC-1:0]   grant,
    output logic                 busy,
    output logic                 underrun
);
    localparam logic [2:0] IDLE = 3'd0, PREAMBLE = 3'd1, SFD = 3'd2, PAYLOAD = 3'd3, PAD = 3'd4, IFG = 3'd5;
    localparam int PW = NUM_SRC > 1 ? $clog2(NUM_SRC) : 1;
    localparam int BW = BYTE_CYCLES > 1 ? $clog2(BYTE_CYCLES) : 1;
    localparam logic [15:0] MIN_LEN = 16'(MIN_PAYLOAD);
    localparam logic [15:0] PRE_LEN = 16'(PREAMBLE_BYTES);
    localparam logic [15:0] IFG_END = 16'(BYTE_CYCLES * (IFG_BYTES + 1) - 2);

    logic [2:0]    state;
    logic [PW-1:0] ptr, nxt;
    logic [BW-1:0] phase;
    logic [15:0]   cnt, cnt_inc;
    logic          fire, found, cur_valid, cur_last, done_payload;
    logic [7:0]    cur_data;

    always_comb begin
        nxt   = ptr;
        found = 1'b0;
        for (int i = 1; i <= NUM_SRC; i++) begin
            if (!found && src_valid[(int'(ptr) + i) % NUM_SRC]) begin
                found = 1'b1;
                nxt   = PW'((int'(ptr) + i) % NUM_SRC);
            end
        end
    end

    // ptr holds the owner for the whole frame and doubles as the round-robin pointer
    assign cur_valid    = src_valid[ptr];
    assign cur_last     = src_last[ptr];
    assign cur_data     = src_data[8*int'(ptr) +: 8];
    assign fire         = (state inside {PREAMBLE, SFD, PAYLOAD, PAD}) && phase == BW'(BYTE_CYCLES - 1);
    assign cnt_inc      = cnt < MIN_LEN ? cnt + 16'd1 : cnt;
    assign done_payload = cur_valid && cur_last;
    assign src_ready    = (state == PAYLOAD && fire) ? NUM_SRC'(1) << ptr : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= PW'(NUM_SRC - 1);
            phase     <= '0;
            cnt       <= '0;
            valid_out <= 1'b0;
            byte_out  <= 8'h00;
            grant     <= '0;
            busy      <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            valid_out <= fire;
            underrun  <= 1'b0;
            phase     <= fire ? '0 : phase + 1'b1;
            case (state)
                IDLE: if (|src_valid) begin
                    ptr       <= nxt;
                    grant     <= NUM_SRC'(1) << nxt;
                    busy      <= 1'b1;
                    valid_out <= 1'b1;
                    byte_out  <= 8'h55;
                    cnt       <= 16'd1;
                    phase     <= '0;
                    state     <= PREAMBLE_BYTES > 1 ? PREAMBLE : SFD;
                end
                PREAMBLE: if (fire) begin
                    byte_out <= 8'h55;
                    cnt      <= cnt + 16'd1;
                    state    <= cnt + 16'd1 == PRE_LEN ? SFD : PREAMBLE;
                end
                SFD: if (fire) begin
                    byte_out <= 8'hD5;
                    cnt      <= '0;
                    state    <= PAYLOAD;
                end
                PAYLOAD: if (fire) begin
                    byte_out <= cur_valid ? cur_data : 8'h00;
                    underrun <= !cur_valid;
                    cnt      <= done_payload && cnt_inc >= MIN_LEN ? '0 : cnt_inc;
                    state    <= done_payload ? (cnt_inc < MIN_LEN ? PAD : IFG) : PAYLOAD;
                end
                PAD: if (fire) begin
                    byte_out <= 8'h00;
                    cnt      <= cnt + 16'd1 >= MIN_LEN ? '0 : cnt + 16'd1;
                    state    <= cnt + 16'd1 >= MIN_LEN ? IFG : PAD;
                end
                IFG: begin
                    grant <= '0;
                    cnt   <= cnt + 16'd1;
                    busy  <= cnt != IFG_END;
                    state <= cnt == IFG_END ? IDLE : IFG;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_eth_tx_scheduler.sv
// tb_eth_tx_scheduler: random frame traffic against a frame-level reference model with a strobe scoreboard
module tb_eth_tx_scheduler;
    typedef struct packed {
        logic [7:0] b;
        logic       u;
        logic [1:0] g;
        logic       first;
        logic       fin;
        logic       b2b;
    } exp_t;

    logic       clk = 1'b0, rst = 1'b1;
    logic [1:0] src_valid = '0, src_last = '0, src_ready, grant;
    logic [15:0] src_data = '0;
    logic       valid_out, busy, underrun;
    logic [7:0] byte_out;

    int pass = 0, total = 0, cyc = 0, prev = 0, last_l = 0, mlast = 1, nf = 0;
    int rc[2], rc_exp[2];
    int f_src[8], f_off[8], f_len[8];
    logic       fin_pending = 1'b0;
    logic [1:0] rdy_seen = '0;
    logic [9:0] q0[$], q1[$], fb[$];
    exp_t       expq[$];

    eth_tx_scheduler dut (
        .clk(clk), .rst(rst), .src_valid(src_valid), .src_data(src_data), .src_last(src_last),
        .src_ready(src_ready), .valid_out(valid_out), .byte_out(byte_out), .grant(grant),
        .busy(busy), .underrun(underrun)
    );

    initial forever #5 clk = ~clk;
    initial forever begin @(posedge clk); cyc++; end

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act === expv) pass++;
        else $display("FAIL %s: got %0h expected %0h at cycle %0d", n, act, expv, cyc);
    endtask

    task automatic drive();
        src_valid[0]  = q0.size() > 0 && !q0[0][9];
        src_last[0]   = q0.size() > 0 ? q0[0][8] : 1'b0;
        src_data[7:0] = q0.size() > 0 ? q0[0][7:0] : 8'h00;
        src_valid[1]  = q1.size() > 0 && !q1[0][9];
        src_last[1]   = q1.size() > 0 ? q1[0][8] : 1'b0;
        src_data[15:8] = q1.size() > 0 ? q1[0][7:0] : 8'h00;
    endtask

    // sources advance one byte on every consume strobe, holes included
    initial forever begin
        @(posedge clk);
        #1;
        if (rdy_seen[0] && q0.size() > 0) void'(q0.pop_front());
        if (rdy_seen[1] && q1.size() > 0) void'(q1.pop_front());
        rdy_seen = '0;
        drive();
    end

    initial forever begin
        exp_t e;
        @(negedge clk);
        rdy_seen |= src_ready;
        for (int i = 0; i < 2; i++) if (src_ready[i]) rc[i]++;
        if (|(src_ready & ~grant)) chk("ready_owner", 32'(src_ready & ~grant), 0);
        if (underrun && !valid_out) chk("underrun_off_strobe", 1, 0);
        if (fin_pending && cyc == last_l + 1) begin
            chk("grant_clear", 32'(grant), 0);
            fin_pending = 1'b0;
        end
        if (valid_out) begin
            if (expq.size() == 0) chk("extra_strobe", 32'(byte_out), 32'hFFFF);
            else begin
                e = expq.pop_front();
                chk("byte", 32'(byte_out), 32'(e.b));
                chk("underrun", 32'(underrun), 32'(e.u));
                chk("grant", 32'(grant), 32'(e.g));
                if (!e.first) chk("byte_spacing", cyc - prev, 4);
                else if (e.b2b) chk("ifg_gap", cyc - last_l, 52);
                prev = cyc;
                if (e.fin) begin last_l = cyc; fin_pending = 1'b1; end
            end
        end
    end

    task automatic add_frame(input int s, input int len, input int base, input bit rnd, input int hole);
        f_src[nf] = s; f_off[nf] = fb.size(); f_len[nf] = len;
        for (int j = 0; j < len; j++) begin
            logic [7:0] d = rnd ? 8'($urandom) : 8'(base + j);
            logic [9:0] w = {j == hole, j == len - 1, d};
            fb.push_back(w);
            if (s == 0) q0.push_back(w); else q1.push_back(w);
        end
        nf++;
    endtask

    task automatic push_frame(input int k, input bit b2b);
        logic [1:0] g = 2'(1 << f_src[k]);
        int n = 0;
        for (int i = 0; i < 7; i++) expq.push_back('{8'h55, 1'b0, g, i == 0, 1'b0, b2b});
        expq.push_back('{8'hD5, 1'b0, g, 1'b0, 1'b0, 1'b0});
        for (int j = 0; j < f_len[k]; j++) begin
            logic [9:0] w = fb[f_off[k] + j];
            expq.push_back('{w[9] ? 8'h00 : w[7:0], w[9], g, 1'b0, 1'b0, 1'b0});
            n++;
        end
        for (; n < 60; n++) expq.push_back('{8'h00, 1'b0, g, 1'b0, 1'b0, 1'b0});
        expq[expq.size() - 1].fin = 1'b1;
        rc_exp[f_src[k]] += f_len[k];
    endtask

    // frame order follows round-robin over sources that still hold frames
    task automatic commit();
        bit used[8];
        for (int k = 0; k < 8; k++) used[k] = 1'b0;
        for (int n = 0; n < nf; n++) begin
            int pick = -1;
            for (int o = 1; o <= 2; o++) begin
                int s = (mlast + o) % 2;
                for (int k = 0; k < nf; k++) if (pick < 0 && !used[k] && f_src[k] == s) pick = k;
            end
            used[pick] = 1'b1;
            mlast = f_src[pick];
            push_frame(pick, n > 0);
        end
        nf = 0;
        fb.delete();
    endtask

    task automatic drain();
        int t = 0;
        while (expq.size() > 0 && t < 30000) begin @(negedge clk); t++; end
        chk("drain_left", 32'(expq.size()), 0);
        t = 0;
        while (busy && t < 200) begin @(negedge clk); t++; end
        chk("busy_drop", cyc - last_l, 51);
        chk("ready_cnt0", rc[0], rc_exp[0]);
        chk("ready_cnt1", rc[1], rc_exp[1]);
        rc = '{0, 0};
        rc_exp = '{0, 0};
    endtask

    initial begin
        rc = '{0, 0};
        rc_exp = '{0, 0};
        repeat (3) @(negedge clk);
        chk("rst_valid_out", 32'(valid_out), 0);
        chk("rst_byte_out", 32'(byte_out), 0);
        chk("rst_grant", 32'(grant), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_underrun", 32'(underrun), 0);
        chk("rst_src_ready", 32'(src_ready), 0);
        rst = 1'b0;
        @(negedge clk);
        add_frame(0, 64, 0, 0, -1);
        commit();
        drain();
        add_frame(1, 10, 'hA0, 0, -1);
        commit();
        drain();
        add_frame(0, 60, 0, 1, -1);
        add_frame(1, 60, 0, 1, -1);
        add_frame(0, 60, 0, 1, -1);
        commit();
        drain();
        add_frame(0, 30, 0, 1, 5);
        commit();
        drain();
        for (int k = 0; k < 5; k++) begin
            int len = $urandom_range(1, 70);
            add_frame(int'($urandom_range(0, 1)), len, 0, 1, (len >= 3 && $urandom_range(0, 1) == 1) ? int'($urandom_range(1, len - 2)) : -1);
        end
        commit();
        drain();
        begin
            int n = 0, t = 0;
            add_frame(0, 64, 0, 0, -1);
            commit();
            while (n < 29 && t < 2000) begin @(negedge clk); if (valid_out) n++; t++; end
            chk("mid_strobe_byte20", 32'(byte_out), 20);
            #1 rst = 1'b1;
            #1;
            chk("async_valid_out", 32'(valid_out), 0);
            chk("async_grant", 32'(grant), 0);
            chk("async_busy", 32'(busy), 0);
            expq.delete(); q0.delete(); q1.delete();
            rdy_seen = '0; rc = '{0, 0}; rc_exp = '{0, 0}; nf = 0; fb.delete();
            mlast = 1; fin_pending = 1'b0;
            @(posedge clk);
            @(negedge clk);
            rst = 1'b0;
            add_frame(1, 10, 'h30, 0, -1);
            commit();
            drain();
        end
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule

// File: doc/eth_tx_scheduler.md
Name: eth_tx_scheduler

Overview:
- Ethernet TX front end. Arbitrates whole frames between NUM_SRC byte-stream requesters, for example H.264 NAL packetiser and control/ARP responder.
- Prepends preamble/SFD, pads short payloads and enforces the inter-frame gap.
- Paces bytes at one per BYTE_CYCLES clocks into the byte-to-dibit TX FIFO buffer, which drives the RMII dibit output.

Parameters:
- NUM_SRC, 2, number of frame requesters.
- BYTE_CYCLES, 4, clocks per emitted byte (RMII 2 bits/clk).
- PREAMBLE_BYTES, 7, count of 0x55 bytes before SFD.
- IFG_BYTES, 12, inter-frame gap in byte times.
- MIN_PAYLOAD, 60, minimum post-SFD bytes; shorter frames are zero-padded.

Ports:
- clk  in  1  system clock (50 MHz RMII domain); all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- src_valid  in  NUM_SRC  per-source byte/frame-request valid.
- src_data  in  8*NUM_SRC  per-source byte, source i at [8i+7:8i].
- src_last  in  NUM_SRC  marks final payload byte of frame.
- src_ready  out  NUM_SRC  one-cycle consume strobe to granted source.
- valid_out  out  1  byte strobe to FIFO buffer valid_in.
- byte_out  out  8  byte to FIFO buffer byte_in.
- grant  out  NUM_SRC  one-hot owner of the current frame; 0 when idle.
- busy  out  1  high from grant through end of IFG.
- underrun  out  1  one-cycle pulse when granted source not valid at a payload slot.

Behaviour:
- Reset (async, any state): state=IDLE; valid_out=0, byte_out=0x00, grant=0, busy=0, underrun=0, src_ready=0; round-robin last-granted pointer=NUM_SRC-1, so source 0 has priority first. Reset mid-frame truncates the frame immediately; no IFG is applied afterwards.
- States: IDLE, PREAMBLE, SFD, PAYLOAD, PAD, IFG.
- IDLE, any src_valid high in cycle T:
  - Round-robin grant goes to the first requester after last-granted, wrapping; pointer updates to it.
  - grant and busy are registered high from T+1.
  - State goes to PREAMBLE.
- Pacing:
  - Frame byte k (preamble = k0) has valid_out high only in cycle T+1+k*BYTE_CYCLES, a single-cycle strobe.
  - byte_out is held until the next strobe.
  - valid_out is never high in IDLE or IFG.
- PREAMBLE: PREAMBLE_BYTES strobes of 0x55. SFD: one strobe of 0xD5. Then PAYLOAD.
- PAYLOAD:
  - For payload byte slot at cycle S, src_ready[g] is high combinationally in cycle S-1 only. src_data[g] is sampled at that edge and presented at S.
  - If src_valid[g] is low in S-1: emit 0x00, pulse underrun at S, and count the byte. No stall; the frame continues.
  - Payload byte counter saturates at MIN_PAYLOAD.
  - On accepting a byte with src_last=1: go to PAD if count < MIN_PAYLOAD, else IFG.
- PAD: emit 0x00 strobes until payload+pad = MIN_PAYLOAD, then IFG. src_ready stays low.
- IFG:
  - Let L = cycle of the frame's last strobe.
  - grant clears at L+1.
  - busy stays high until cycle L+BYTE_CYCLES*(IFG_BYTES+1)-2, then state=IDLE and busy=0.
  - With a requester waiting, the next frame's first strobe is at exactly L+BYTE_CYCLES*(IFG_BYTES+1).
- src_valid changes while not granted or not in a payload slot are ignored. Non-granted sources never see src_ready.
- Total strobes per frame = PREAMBLE_BYTES+1+max(payload, MIN_PAYLOAD).

Test Plan:
- Src0 sends 64-byte frame 0x00..0x3F, src1 idle:
  - 72 strobes spaced 4 clocks: 7×0x55, 0xD5, then 0x00..0x3F.
  - grant=01 throughout; busy drops 51 cycles after last strobe.
- Src1 sends 10-byte frame 0xA0..0xA9:
  - 8 preamble/SFD strobes, 10 data strobes, 50 0x00 pad strobes (68 total).
  - src_ready pulses exactly 10 times.
- Both sources request continuously with 60-byte frames:
  - Grants alternate 01,10,01.
  - First strobe of each next frame is exactly 52 cycles after previous last strobe.
- Src0 drops src_valid for payload byte 5:
  - byte 5 emitted 0x00, underrun pulses once at that strobe.
  - Frame length and timing unchanged.
- Assert rst during PAYLOAD byte 20:
  - Same cycle: valid_out=0, grant=0, busy=0.
  - After release with src1 requesting: src1 is granted first (pointer reset to NUM_SRC-1 → src0 priority only if src0 requests), preamble restarts at 0x55.
